// File: rtl/step_sequencer_if.sv
// Control, pattern-write and note-output bundle of the step sequencer.
// The master side (player/controller) drives tick, go, last_step and the
// pattern write port; the slave side (the sequencer) drives the issued
// step, note and gate outputs.
interface step_sequencer_if;
  logic       tick;
  logic       go;
  logic [3:0] last_step;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [3:0] wr_data;
  logic [3:0] note;
  logic [3:0] step;
  logic       note_valid;
  logic       gate;
  logic       bar_pulse;

  modport master (
    output tick, go, last_step, wr_en, wr_addr, wr_data,
    input  note, step, note_valid, gate, bar_pulse
  );

  modport slave (
    input  tick, go, last_step, wr_en, wr_addr, wr_data,
    output note, step, note_valid, gate, bar_pulse
  );
endinterface

// File: rtl/step_sequencer.sv
// 16-step note sequencer. Each tick while running issues the note stored
// at the current step pointer, advances the pointer (wrapping after
// last_step) and opens a gate that stays high GATE_CYCLES clocks unless
// retriggered by the next non-rest step or closed by a rest step.
module step_sequencer #(
  parameter int unsigned GATE_CYCLES = 2500000
) (
  input  logic              clk,
  input  logic              reset,
  step_sequencer_if.slave   bus
);

  localparam logic [21:0] GATE_LOAD = 22'(GATE_CYCLES);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state;
  logic [3:0]  ptr;
  logic [21:0] gate_cnt;

  logic [3:0]  pattern [16];

  logic [3:0]  note_p1;
  logic [3:0]  step_p1;
  logic        vld_p1;
  logic        gate_p1;
  logic        bar_p1;

  logic [3:0]  cur_note;
  logic        is_wrap;

  // Current step lookup and wrap decision; the pointer wraps on >= so a
  // last_step lowered below the pointer mid-run still wraps on the next tick.
  always_comb begin
    cur_note = pattern[ptr];
    is_wrap  = (ptr >= bus.last_step);
  end

  // Pattern store; a write in the tick cycle lands after the tick's read,
  // because the read above sees the pre-edge contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        pattern[i] <= 4'd0;
      end
    end else if (bus.wr_en) begin
      pattern[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Run/idle FSM with registered step, note, pulse and gate outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= 4'd0;
      gate_cnt <= 22'd0;
      note_p1  <= 4'd0;
      step_p1  <= 4'd0;
      vld_p1   <= 1'b0;
      gate_p1  <= 1'b0;
      bar_p1   <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      bar_p1 <= 1'b0;
      case (state)
        IDLE: begin
          // Ticks are ignored here, including one coincident with go rising.
          ptr      <= 4'd0;
          gate_cnt <= 22'd0;
          gate_p1  <= 1'b0;
          if (bus.go) begin
            state <= RUN;
          end
        end

        RUN: begin
          if (!bus.go) begin
            // Stopping closes any open gate and rewinds to step 0.
            state    <= IDLE;
            ptr      <= 4'd0;
            gate_cnt <= 22'd0;
            gate_p1  <= 1'b0;
          end else if (bus.tick) begin
            step_p1 <= ptr;
            note_p1 <= cur_note;
            bar_p1  <= (ptr == 4'd0);
            ptr     <= is_wrap ? 4'd0 : ptr + 4'd1;
            if (cur_note != 4'd0) begin
              // Non-rest: open or retrigger the gate with no low cycle.
              vld_p1   <= 1'b1;
              gate_p1  <= 1'b1;
              gate_cnt <= GATE_LOAD;
            end else begin
              gate_p1  <= 1'b0;
              gate_cnt <= 22'd0;
            end
          end else begin
            // Gate was raised with the counter at GATE_LOAD; it closes on
            // the edge where the counter would pass 1, giving exactly
            // GATE_CYCLES high cycles.
            if (gate_cnt > 22'd1) begin
              gate_cnt <= gate_cnt - 22'd1;
            end else begin
              gate_cnt <= 22'd0;
              gate_p1  <= 1'b0;
            end
          end
        end

        default: begin
          state   <= IDLE;
          ptr     <= 4'd0;
          gate_p1 <= 1'b0;
        end
      endcase
    end
  end

  assign bus.note       = note_p1;
  assign bus.step       = step_p1;
  assign bus.note_valid = vld_p1;
  assign bus.gate       = gate_p1;
  assign bus.bar_pulse  = bar_p1;

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer with an 8-cycle gate. Inputs change
// 1 ns after the rising edge; outputs are checked at the same point.
module tb_step_sequencer;

  localparam int unsigned GATE = 8;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  step_sequencer_if sif ();

  step_sequencer #(.GATE_CYCLES(GATE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] addr, input logic [3:0] data);
    sif.wr_en   = 1'b1;
    sif.wr_addr = addr;
    sif.wr_data = data;
    cyc(1);
    sif.wr_en   = 1'b0;
  endtask

  task automatic tick_pulse();
    sif.tick = 1'b1;
    cyc(1);
    sif.tick = 1'b0;
  endtask

  task automatic check_issue(input string tag, input logic [3:0] stp,
                             input logic [3:0] nt, input logic nv,
                             input logic bar);
    check({tag, ".step"}, 32'(sif.step), 32'(stp));
    check({tag, ".note"}, 32'(sif.note), 32'(nt));
    check({tag, ".nv"},   32'(sif.note_valid), 32'(nv));
    check({tag, ".bar"},  32'(sif.bar_pulse), 32'(bar));
  endtask

  task automatic check_gate(input string tag, input logic exp);
    check(tag, 32'(sif.gate), 32'(exp));
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    reset         = 1'b1;
    sif.tick      = 1'b0;
    sif.go        = 1'b0;
    sif.last_step = 4'd3;
    sif.wr_en     = 1'b0;
    sif.wr_addr   = 4'd0;
    sif.wr_data   = 4'd0;

    // Reset state
    cyc(2);
    check_issue("rst", 4'd0, 4'd0, 1'b0, 1'b0);
    check_gate("rst.gate", 1'b0);
    reset = 1'b0;
    cyc(1);

    // Basic run
    wr(4'd0, 4'd1);
    wr(4'd1, 4'd2);
    wr(4'd2, 4'd3);
    wr(4'd3, 4'd4);
    sif.go   = 1'b1;
    sif.tick = 1'b1;          // coincident with IDLE->RUN: must be ignored
    cyc(1);
    sif.tick = 1'b0;
    check("start.nv", 32'(sif.note_valid), 32'd0);
    check_gate("start.gate", 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick_pulse();
      check_issue("basic", 4'(i % 4), 4'((i % 4) + 1), 1'b1, (i % 4) == 0);
      check_gate("basic.gate0", 1'b1);
      cyc(7);
      check_gate("basic.gate7", 1'b1);
      check("basic.nvlow", 32'(sif.note_valid), 32'd0);
      cyc(1);
      check_gate("basic.gate8", 1'b0);
      cyc(10);
    end

    // Rest and retrigger (ptr is at 1)
    wr(4'd1, 4'd0);
    tick_pulse();
    check_issue("rest1", 4'd1, 4'd0, 1'b0, 1'b0);
    check_gate("rest1.gate", 1'b0);
    tick_pulse();
    check_issue("rt2", 4'd2, 4'd3, 1'b1, 1'b0);
    check_gate("rt2.gate", 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check_gate("rt2.hold", 1'b1);
    end
    tick_pulse();
    check_issue("rt3", 4'd3, 4'd4, 1'b1, 1'b0);
    check_gate("rt3.gate", 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check_gate("rt3.hold", 1'b1);
    end
    tick_pulse();
    check_issue("rt0", 4'd0, 4'd1, 1'b1, 1'b1);
    check_gate("rt0.gate", 1'b1);
    cyc(3);
    tick_pulse();
    check_issue("rest1b", 4'd1, 4'd0, 1'b0, 1'b0);
    check_gate("rest1b.gate", 1'b0);
    cyc(3);

    // Write collision (ptr is at 2, pattern[2]=3)
    sif.wr_en   = 1'b1;
    sif.wr_addr = 4'd2;
    sif.wr_data = 4'd9;
    tick_pulse();
    sif.wr_en   = 1'b0;
    check_issue("coll.old", 4'd2, 4'd3, 1'b1, 1'b0);
    cyc(2);
    tick_pulse();
    cyc(2);
    tick_pulse();
    cyc(2);
    tick_pulse();
    check_issue("coll.s1", 4'd1, 4'd0, 1'b0, 1'b0);
    cyc(2);
    tick_pulse();
    check_issue("coll.new", 4'd2, 4'd9, 1'b1, 1'b0);
    cyc(2);

    // last_step shrink (ptr is at 3)
    sif.last_step = 4'd15;
    wr(4'd6, 4'd7);
    tick_pulse();
    check_issue("shr3", 4'd3, 4'd4, 1'b1, 1'b0);
    tick_pulse();
    check_issue("shr4", 4'd4, 4'd0, 1'b0, 1'b0);
    tick_pulse();
    check_issue("shr5", 4'd5, 4'd0, 1'b0, 1'b0);
    sif.last_step = 4'd3;
    tick_pulse();
    check_issue("shr6", 4'd6, 4'd7, 1'b1, 1'b0);
    tick_pulse();
    check_issue("shrwrap", 4'd0, 4'd1, 1'b1, 1'b1);

    // go drop mid-gate
    tick_pulse();
    tick_pulse();
    check_issue("gd2", 4'd2, 4'd9, 1'b1, 1'b0);
    cyc(1);
    check_gate("gd.before", 1'b1);
    sif.go = 1'b0;
    cyc(1);
    check_gate("gd.after", 1'b0);
    tick_pulse();
    check_issue("gd.ignored", 4'd2, 4'd9, 1'b0, 1'b0);
    check_gate("gd.ignored.gate", 1'b0);
    sif.go = 1'b1;
    cyc(1);
    tick_pulse();
    check_issue("restart", 4'd0, 4'd1, 1'b1, 1'b1);
    check_gate("restart.gate", 1'b1);

    // Asynchronous reset mid-run
    tick_pulse();
    tick_pulse();
    check_issue("prerst", 4'd2, 4'd9, 1'b1, 1'b0);
    reset = 1'b1;
    #2;
    check_issue("arst", 4'd0, 4'd0, 1'b0, 1'b0);
    check_gate("arst.gate", 1'b0);
    sif.go = 1'b0;
    cyc(1);
    reset = 1'b0;
    tick_pulse();
    check("postrst.idle.nv", 32'(sif.note_valid), 32'd0);
    check("postrst.idle.bar", 32'(sif.bar_pulse), 32'd0);
    sif.go = 1'b1;
    cyc(1);
    tick_pulse();
    check_issue("clr0", 4'd0, 4'd0, 1'b0, 1'b1);
    check_gate("clr0.gate", 1'b0);
    tick_pulse();
    tick_pulse();
    check_issue("clr2", 4'd2, 4'd0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
